// File: rtl/pio_bank_if.sv
// Avalon-MM slave bus bundle for pio_bank: word address, read/write strobes, 32-bit data.
interface pio_bank_if #(
  parameter int AW = 4
) ();
  logic [AW-1:0] avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/pio_bank.sv
// Multi-channel PIO bank: synchronised inputs with edge capture, output registers,
// per-channel interrupt masks and a single registered level interrupt.
module pio_bank #(
  parameter int            NCH       = 4,
  parameter int            W         = 16,
  parameter int            EDGE_MODE = 0,
  parameter logic [W-1:0]  OUT_RESET = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  pio_bank_if.slave        avs,
  input  logic [NCH*W-1:0] in_export,
  output logic [NCH*W-1:0] out_export,
  output logic             irq
);
  localparam int AW = $clog2(NCH) + 2;
  localparam int CW = (AW > 2) ? AW - 2 : 1;

  logic [CW-1:0]    chan;
  logic [1:0]       reg_sel;
  logic             chan_ok;
  logic             wr_en;
  logic             rd_en;
  logic [NCH*W-1:0] in_all;
  logic [NCH*W-1:0] out_all;
  logic [NCH*W-1:0] mask_all;
  logic [NCH*W-1:0] edge_all;

  logic [1:0]       arm_cnt_q, arm_cnt_d;
  logic             armed;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic [W-1:0]     rsel;

  // A single-channel bank has no channel field in the address.
  generate
    if (AW > 2) begin : g_chan
      assign chan = avs.avs_address[AW-1:2];
    end else begin : g_chan1
      assign chan = '0;
    end
    if (W < 32) begin : g_wd_unused
      logic unused_wd;
      assign unused_wd = ^avs.avs_writedata[31:W];
    end
  endgenerate

  assign reg_sel = avs.avs_address[1:0];
  assign chan_ok = ({1'b0, chan} < (CW + 1)'(NCH));
  assign wr_en   = avs.avs_write & chan_ok;
  assign rd_en   = avs.avs_read & ~avs.avs_write;
  assign armed   = (arm_cnt_q == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [W-1:0] s1_q, s1_d;
      logic [W-1:0] s2_q, s2_d;
      logic [W-1:0] prev_q, prev_d;
      logic [W-1:0] out_q, out_d;
      logic [W-1:0] mask_q, mask_d;
      logic [W-1:0] edge_q, edge_d;
      logic [W-1:0] det;
      logic [W-1:0] set;
      logic         hit;

      assign hit = wr_en && (chan == CW'(gi));

      always_comb begin
        case (EDGE_MODE)
          0:       det = s2_q & ~prev_q;
          1:       det = ~s2_q & prev_q;
          default: det = s2_q ^ prev_q;
        endcase
        set    = det & {W{armed}};
        s1_d   = in_export[gi*W +: W];
        s2_d   = s1_q;
        prev_d = s2_q;
        out_d  = out_q;
        mask_d = mask_q;
        edge_d = edge_q | set;
        if (hit) begin
          case (reg_sel)
            2'd1:    out_d  = avs.avs_writedata[W-1:0];
            2'd2:    mask_d = avs.avs_writedata[W-1:0];
            // Clear first, then OR in new captures so a same-cycle edge survives.
            2'd3:    edge_d = (edge_q & ~avs.avs_writedata[W-1:0]) | set;
            default: ;
          endcase
        end
      end

      always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
          s1_q   <= '0;
          s2_q   <= '0;
          prev_q <= '0;
          out_q  <= OUT_RESET;
          mask_q <= '0;
          edge_q <= '0;
        end else begin
          s1_q   <= s1_d;
          s2_q   <= s2_d;
          prev_q <= prev_d;
          out_q  <= out_d;
          mask_q <= mask_d;
          edge_q <= edge_d;
        end
      end

      assign in_all[gi*W +: W]   = s2_q;
      assign out_all[gi*W +: W]  = out_q;
      assign mask_all[gi*W +: W] = mask_q;
      assign edge_all[gi*W +: W] = edge_q;
    end
  endgenerate

  always_comb begin
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
    irq_d     = |(edge_all & mask_all);
    rdata_d   = rdata_q;
    rsel      = '0;
    if (rd_en) begin
      for (int c = 0; c < NCH; c++) begin
        if (chan_ok && (chan == CW'(c))) begin
          case (reg_sel)
            2'd0:    rsel = in_all[c*W +: W];
            2'd1:    rsel = out_all[c*W +: W];
            2'd2:    rsel = mask_all[c*W +: W];
            default: rsel = edge_all[c*W +: W];
          endcase
        end
      end
      rdata_d = 32'(rsel);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      arm_cnt_q <= 2'd0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign avs.avs_readdata = rdata_q;
  assign out_export       = out_all;
  assign irq              = irq_q;
endmodule

// File: tb/tb_pio_bank.sv
// Scoreboarded bench for pio_bank: three instances (rising/NCH4, any-edge/NCH4, rising/NCH3)
// share one bus driver, selected per transaction.
module tb_pio_bank;
  logic        clk;
  logic        rst;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  int          sel;
  logic [63:0] in0, in2, out0, out2;
  logic [47:0] in3, out3;
  logic        irq0, irq2, irq3;

  int n_checks = 0;
  int n_fail   = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  logic        rd_pend = 1'b0;
  int          sel_pend = 0;
  logic [31:0] got;
  string       tag_cur;
  logic [31:0] exp_cur;

  pio_bank_if #(.AW(4)) bus0 ();
  pio_bank_if #(.AW(4)) bus2 ();
  pio_bank_if #(.AW(4)) bus3 ();

  assign bus0.avs_address = addr;
  assign bus2.avs_address = addr;
  assign bus3.avs_address = addr;
  assign bus0.avs_writedata = wdata;
  assign bus2.avs_writedata = wdata;
  assign bus3.avs_writedata = wdata;
  assign bus0.avs_read  = rd && (sel == 0);
  assign bus2.avs_read  = rd && (sel == 1);
  assign bus3.avs_read  = rd && (sel == 2);
  assign bus0.avs_write = wr && (sel == 0);
  assign bus2.avs_write = wr && (sel == 1);
  assign bus3.avs_write = wr && (sel == 2);

  pio_bank #(.NCH(4), .W(16), .EDGE_MODE(0), .OUT_RESET(16'h5A5A)) dut0 (
    .clk_clk(clk), .reset_reset(rst), .avs(bus0.slave),
    .in_export(in0), .out_export(out0), .irq(irq0));
  pio_bank #(.NCH(4), .W(16), .EDGE_MODE(2), .OUT_RESET(16'h0000)) dut2 (
    .clk_clk(clk), .reset_reset(rst), .avs(bus2.slave),
    .in_export(in2), .out_export(out2), .irq(irq2));
  pio_bank #(.NCH(3), .W(16), .EDGE_MODE(0), .OUT_RESET(16'h0000)) dut3 (
    .clk_clk(clk), .reset_reset(rst), .avs(bus3.slave),
    .in_export(in3), .out_export(out3), .irq(irq3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic rd_reg(input int s, input int ch, input int r, input logic [31:0] exp,
                        input string tag);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    sel  = s;
    addr = 4'(ch * 4 + r);
    rd   = 1'b1;
    @(negedge clk);
    rd   = 1'b0;
  endtask

  task automatic wr_reg(input int s, input int ch, input int r, input logic [31:0] d);
    $display("wr  dut=%0d ch=%0d reg=%0d data=%08h", s, ch, r, d);
    sel   = s;
    addr  = 4'(ch * 4 + r);
    wdata = d;
    wr    = 1'b1;
    @(negedge clk);
    wr    = 1'b0;
  endtask

  always @(posedge clk) begin
    rd_pend  <= rd && !wr;
    sel_pend <= sel;
  end

  // Read data is registered, so it is compared on the falling edge after the accepting clock.
  always @(negedge clk) begin
    if (rd_pend) begin
      got = (sel_pend == 0) ? bus0.avs_readdata :
            (sel_pend == 1) ? bus2.avs_readdata : bus3.avs_readdata;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got %08h expected none", got);
      end else begin
        tag_cur = tag_q.pop_front();
        exp_cur = exp_q.pop_front();
        $display("rd  dut=%0d %s data=%08h", sel_pend, tag_cur, got);
        chk(tag_cur, 64'(got), 64'(exp_cur));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; sel = 0; addr = '0; wdata = '0;
    in0 = '1; in2 = '0; in3 = {16'hFFFF, 16'h1234, 16'h5678};
    repeat (4) @(negedge clk);
    chk("rst_irq0", 64'(irq0), 64'd0);
    chk("rst_rdata0", 64'(bus0.avs_readdata), 64'd0);
    chk("rst_out0", out0, {4{16'h5A5A}});
    chk("rst_out3", 64'(out3), 64'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Inputs held high through reset must not leave edge bits behind.
    for (int c = 0; c < 4; c++) rd_reg(0, c, 3, 32'd0, $sformatf("arm_edge%0d", c));
    chk("arm_irq", 64'(irq0), 64'd0);
    in0 = '0;
    repeat (5) @(negedge clk);
    rd_reg(0, 1, 3, 32'd0, "fall_ignored");

    wr_reg(0, 2, 1, 32'hFFFF_ABCD);
    chk("out_ch2", 64'(out0[47:32]), 64'hABCD);
    chk("out_other", {16'd0, out0[63:48], out0[31:0]}, {16'd0, 16'h5A5A, 32'h5A5A_5A5A});
    rd_reg(0, 2, 1, 32'h0000_ABCD, "rd_out2");

    // Simultaneous read and write: write lands, read data holds.
    sel = 0; addr = 4'(1 * 4 + 2); wdata = 32'h1; rd = 1'b1; wr = 1'b1;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    chk("rdwr_hold", 64'(bus0.avs_readdata), 64'h0000_ABCD);
    rd_reg(0, 1, 2, 32'h1, "mask1");

    in0[16] = 1'b1;
    @(negedge clk); chk("lat_k", 64'(irq0), 64'd0);
    @(negedge clk); chk("lat_k1", 64'(irq0), 64'd0);
    rd_reg(0, 1, 3, 32'd0, "edge_k2");
    chk("lat_k2", 64'(irq0), 64'd0);
    rd_reg(0, 1, 3, 32'd1, "edge_k3");
    chk("lat_k3", 64'(irq0), 64'd1);
    wr_reg(0, 1, 3, 32'h1);
    chk("w1c_j", 64'(irq0), 64'd1);
    @(negedge clk); chk("w1c_j1", 64'(irq0), 64'd0);
    rd_reg(0, 1, 3, 32'd0, "edge_cleared");

    in0[16] = 1'b0; repeat (4) @(negedge clk);
    in0[16] = 1'b1; repeat (4) @(negedge clk);
    chk("pre_coll", 64'(irq0), 64'd1);
    in0[16] = 1'b0; repeat (4) @(negedge clk);
    in0[16] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr_reg(0, 1, 3, 32'h1);
    chk("coll_k2", 64'(irq0), 64'd1);
    @(negedge clk); chk("coll_k3", 64'(irq0), 64'd1);
    rd_reg(0, 1, 3, 32'd1, "coll_edge");

    wr_reg(1, 0, 2, 32'h1);
    in2[0] = 1'b1;
    repeat (3) @(negedge clk);
    wr_reg(1, 0, 3, 32'h1);
    chk("any_rise_irq", 64'(irq2), 64'd1);
    rd_reg(1, 0, 3, 32'd0, "any_once");
    chk("any_irq_clr", 64'(irq2), 64'd0);
    in2[0] = 1'b0;
    repeat (3) @(negedge clk);
    rd_reg(1, 0, 3, 32'd1, "any_fall");
    chk("any_fall_irq", 64'(irq2), 64'd1);

    wr_reg(2, 0, 1, 32'h1111);
    chk("oob_base", 64'(out3), 64'h1111);
    wr_reg(2, 3, 1, 32'hFFFF);
    wr_reg(2, 3, 2, 32'hFFFF);
    chk("oob_out", 64'(out3), 64'h1111);
    for (int r = 0; r < 4; r++) rd_reg(2, 3, r, 32'd0, $sformatf("oob_rd%0d", r));
    rd_reg(2, 1, 0, 32'h1234, "in_ch1");
    wr_reg(2, 1, 0, 32'h0);
    rd_reg(2, 1, 0, 32'h1234, "in_wr_ignored");
    rd_reg(2, 2, 0, 32'hFFFF, "in_ch2");
    chk("oob_irq", 64'(irq3), 64'd0);

    // Reset overrides a concurrent write.
    rst = 1'b1;
    sel = 0; addr = 4'(0 * 4 + 1); wdata = 32'h1234; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    chk("rst_mid_out", out0, {4{16'h5A5A}});
    chk("rst_mid_irq", 64'(irq0), 64'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    rd_reg(0, 1, 3, 32'd0, "rst_mid_edge");
    rd_reg(0, 1, 2, 32'd0, "rst_mid_mask");

    repeat (2) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pio_bank.md
PIO_BANK -- requirements
Module: pio_bank

Parameters
REQ-001 NCH, default 4: number of channels, legal 1..8.
REQ-002 W, default 16: bits per channel, legal 1..32.
REQ-003 EDGE_MODE, default 0: edge-capture mode; 0 = rising, 1 = falling, 2 = any.
REQ-004 OUT_RESET, default 0: reset value of every channel's output register, W bits wide.

Interface
REQ-005 clk_clk  in  1: single clock; all logic on its rising edge.
REQ-006 reset_reset  in  1: synchronous, active-high reset.
REQ-007 avs_address  in  AW=clog2(NCH)+2: word address; [AW-1:2] = channel, [1:0] = register.
REQ-008 avs_read  in  1: read strobe.
REQ-009 avs_write  in  1: write strobe.
REQ-010 avs_writedata  in  32: write data; bits [31:W] ignored.
REQ-011 avs_readdata  out  32: registered read data; bits [31:W] always 0.
REQ-012 in_export  in  NCH*W: asynchronous inputs; channel c occupies [c*W +: W].
REQ-013 out_export  out  NCH*W: output registers, same packing as in_export.
REQ-014 irq  out  1: registered level interrupt.

Function
REQ-015 Register map per channel: 0 IN (read-only), 1 OUT (read/write), 2 MASK (read/write), 3 EDGE (read; write-1-to-clear).
REQ-016 Each in_export bit SHALL pass a 2-flop synchronizer (s1, s2) plus a history flop (prev); IN returns s2.
REQ-017 Edge detect: rising = s2 & ~prev; falling = ~s2 & prev; any = s2 ^ prev; detected bits SHALL OR into EDGE on the next clock.
REQ-018 Latency: an input change sampled at clock k SHALL set EDGE at clock k+2 and assert irq at clock k+3.
REQ-019 When set and W1C hit the same EDGE bit in the same cycle, set SHALL win.
REQ-020 irq SHALL be registered as the OR over all channels of (EDGE & MASK); it stays asserted until the contributing bits are cleared or masked.
REQ-021 Reads SHALL have fixed latency 1: avs_readdata is valid on the clock after avs_read and holds until the next read.
REQ-022 A write to IN SHALL be ignored.
REQ-023 An address whose channel index is >= NCH SHALL read 0; writes to it SHALL be ignored.
REQ-024 If avs_read and avs_write are asserted together, the write SHALL be performed and the read ignored; avs_readdata holds its value.
REQ-025 out_export SHALL equal the OUT registers directly, with no extra pipeline stage, so a write appears on the clock after avs_write.
REQ-026 Post-reset arming: a 2-bit counter SHALL suppress edge detection for the first 3 clocks after reset deasserts, so that inputs held static through reset produce no spurious EDGE bits.

Reset
REQ-027 While reset_reset = 1, the following SHALL be cleared on each clock:
  - s1, s2, prev, MASK, EDGE all 0;
  - irq = 0 and avs_readdata = 0;
  - OUT = OUT_RESET;
  - arming counter = 0.
REQ-028 Reset asserted mid-operation SHALL override any concurrent write or edge in that cycle.

Verification
REQ-029 Reset release with in_export held at all-ones, EDGE_MODE = 0 -> EDGE reads 0 on every channel and irq stays 0.
REQ-030 NCH = 4, W = 16: write 0xABCD to channel 2 OUT -> out_export[47:32] = 0xABCD on the next clock; a read of the same address returns 0x0000ABCD one clock after avs_read.
REQ-031 MASK[1] = 0x0001, rising mode; raise in_export bit 16 at clock k -> EDGE ch1 = 0x0001 at k+2, irq = 1 at k+3; W1C 0x0001 -> irq = 0 one clock after EDGE clears.
REQ-032 A new rising edge on a bit lands in the same cycle as a W1C of that bit -> bit remains 1 and irq stays 1.
REQ-033 EDGE_MODE = 2: pulse an input high for 5 clocks -> EDGE captures the bit once; after W1C, the falling edge re-captures it.
REQ-034 NCH = 3: read channel 3 at any register -> returns 0; a write there leaves all out_export bits unchanged.
